spi_ram_burst: RTL

Parametrised single-port RAM that sits behind the SPI slave receiver and executes its framed commands. Each frame is a 2-bit opcode plus a DATA_W payload. Compared with the fixed 8-bit/256-entry generation, this block adds:
- configurable data width and depth;
- burst auto-increment of the read and write pointers;
- address-valid tracking;
- a protocol-error pulse.

---
 rtl/spi_ram_burst_if.sv | 23 ++
 rtl/spi_ram_burst.sv | 105 ++++++++++
 2 files changed

// File: rtl/spi_ram_burst_if.sv
// rtl/spi_ram_burst_if.sv - framed command/response bus between SPI receiver and burst RAM
interface spi_ram_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [DATA_W+1:0] din;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              cmd_err;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  modport master (
    output rx_valid, din,
    input  dout, tx_valid, cmd_err, wr_ptr, rd_ptr
  );

  modport slave (
    input  rx_valid, din,
    output dout, tx_valid, cmd_err, wr_ptr, rd_ptr
  );
endinterface

// File: rtl/spi_ram_burst.sv
// rtl/spi_ram_burst.sv - single-port RAM executing SPI frames with auto-incrementing burst pointers
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  spi_ram_burst_if.slave  bus
);
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_WIDE = (ADDR_W+1)'(MEM_DEPTH);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_tx_valid;
  logic              r_cmd_err;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_wr_set;
  logic              r_rd_set;

  logic [1:0]        w_opcode;
  logic [DATA_W-1:0] w_payload;
  logic [ADDR_W-1:0] w_addr;
  logic              w_addr_ok;
  logic [ADDR_W-1:0] w_wr_next;
  logic [ADDR_W-1:0] w_rd_next;
  logic              w_do_write;

  assign w_opcode  = bus.din[DATA_W+1:DATA_W];
  assign w_payload = bus.din[DATA_W-1:0];
  assign w_addr    = w_payload[ADDR_W-1:0];
  // Compare one bit wider so MEM_DEPTH == 2**ADDR_W does not overflow.
  assign w_addr_ok = {1'b0, w_addr} < DEPTH_WIDE;
  assign w_wr_next = (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + ADDR_W'(1);
  assign w_rd_next = (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + ADDR_W'(1);

  assign w_do_write = !rst && bus.rx_valid && (w_opcode == OP_WR_DATA) && r_wr_set;

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_wr_ptr] <= w_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_set   <= 1'b0;
      r_rd_set   <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      if (bus.rx_valid) begin
        case (w_opcode)
          OP_WR_ADDR: begin
            if (w_addr_ok) begin
              r_wr_ptr <= w_addr;
              r_wr_set <= 1'b1;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
          OP_WR_DATA: begin
            if (r_wr_set) r_wr_ptr <= w_wr_next;
            else          r_cmd_err <= 1'b1;
          end
          OP_RD_ADDR: begin
            if (w_addr_ok) begin
              r_rd_ptr <= w_addr;
              r_rd_set <= 1'b1;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
          OP_RD_DATA: begin
            if (r_rd_set) begin
              r_dout     <= r_mem[r_rd_ptr];
              r_tx_valid <= 1'b1;
              r_rd_ptr   <= w_rd_next;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.dout     = r_dout;
  assign bus.tx_valid = r_tx_valid;
  assign bus.cmd_err  = r_cmd_err;
  assign bus.wr_ptr   = r_wr_ptr;
  assign bus.rd_ptr   = r_rd_ptr;
endmodule
